al_accel_pu_dap: RTL



---
 rtl/al_accel_pu_dap.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/al_accel_pu_dap.sv
// Distributed-arithmetic processing unit: NUM_CH dot products of offset-adjusted
// inputs against signed weights that are consumed bit-serially, MSB first.
module al_accel_pu_dap #(
  parameter int NUM_CH  = 3,
  parameter int NUM_TAP = 3,
  parameter int WBITS   = 8,
  parameter int IBITS   = 8,
  parameter int ACC_W   = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CH*NUM_TAP*WBITS-1:0] pu_wdi,
  input  logic [NUM_TAP*IBITS-1:0]        pu_idi,
  input  logic [31:0]                     pu_input_offset,
  input  logic                            pu_acc_mode,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [NUM_CH*ACC_W-1:0]         pu_odo,
  output logic                            out_valid,
  input  logic                            out_ready
);

  localparam int LUT_N = 1 << NUM_TAP;
  localparam int CNT_W = (WBITS > 1) ? $clog2(WBITS) : 1;
  localparam int WGT_W = NUM_CH * NUM_TAP * WBITS;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WGT_W-1:0] wgt_q, wgt_d;
  logic             acc_mode_q, acc_mode_d;
  logic [ACC_W-1:0] lut_q [LUT_N];
  logic [ACC_W-1:0] lut_d [LUT_N];
  logic [ACC_W-1:0] acc_q [NUM_CH];
  logic [ACC_W-1:0] acc_d [NUM_CH];
  logic [ACC_W-1:0] odo_q [NUM_CH];
  logic [ACC_W-1:0] odo_d [NUM_CH];

  logic [ACC_W-1:0]   x_val    [NUM_TAP];
  logic [ACC_W-1:0]   lut_new  [LUT_N];
  logic [NUM_TAP-1:0] addr     [NUM_CH];
  logic [ACC_W-1:0]   acc_calc [NUM_CH];
  logic               is_sign;

  // Offset-adjusted inputs and every subset sum of them, built from the live
  // input bus so the table is ready on the accept edge.
  always_comb begin
    lut_new = '{default: '0};
    for (int k = 0; k < NUM_TAP; k++) begin
      x_val[k] = ACC_W'($signed(pu_idi[k*IBITS +: IBITS]))
               + ACC_W'($signed(pu_input_offset));
    end
    for (int m = 0; m < LUT_N; m++) begin
      for (int k = 0; k < NUM_TAP; k++) begin
        if (m[k]) lut_new[m] = lut_new[m] + x_val[k];
      end
    end
  end

  assign is_sign = (cnt_q == CNT_W'(WBITS - 1));

  // The sign bit carries weight -2^(WBITS-1), so the first step subtracts.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      addr[c] = '0;
      for (int k = 0; k < NUM_TAP; k++) begin
        addr[c][k] = wgt_q[(c*NUM_TAP + k)*WBITS + int'(cnt_q)];
      end
      acc_calc[c] = is_sign ? (-lut_q[addr[c]])
                            : ((acc_q[c] << 1) + lut_q[addr[c]]);
    end
  end

  always_comb begin
    // NOTE: every next-state variable takes its hold value first, so no path
    // through the case below can leave one unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    wgt_d      = wgt_q;
    acc_mode_d = acc_mode_q;
    lut_d      = lut_q;
    acc_d      = acc_q;
    odo_d      = odo_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d    = ST_CALC;
          wgt_d      = pu_wdi;
          acc_mode_d = pu_acc_mode;
          lut_d      = lut_new;
          cnt_d      = CNT_W'(WBITS - 1);
        end
      end
      ST_CALC: begin
        acc_d = acc_calc;
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          for (int c = 0; c < NUM_CH; c++) begin
            odo_d[c] = acc_mode_q ? (odo_q[c] + acc_calc[c]) : acc_calc[c];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wgt_q      <= '0;
      acc_mode_q <= 1'b0;
      // NOTE: the LUT and accumulator arrays are cleared too; an aborted
      // transaction must leave nothing behind for the next one.
      lut_q      <= '{default: '0};
      acc_q      <= '{default: '0};
      odo_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wgt_q      <= wgt_d;
      acc_mode_q <= acc_mode_d;
      lut_q      <= lut_d;
      acc_q      <= acc_d;
      odo_q      <= odo_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_odo
    assign pu_odo[c*ACC_W +: ACC_W] = odo_q[c];
  end

endmodule
